// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and branch target,
// followed by the EX/MEM pipeline register feeding the memory stage.
module execute_cycle (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        ALUSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    logic [31:0] src_a;
    logic [31:0] write_data_e;
    logic [31:0] src_b;
    logic [31:0] alu_result_e;
    logic        zero_e;

    // Forward select 11 is unused by the hazard unit and falls back to the register file.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data_e = RD2_E;
        case (ForwardB_E)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = ALU_ResultM;
            default: write_data_e = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;

    always_comb begin
        alu_result_e = 32'h0;
        case (ALUControlE)
            3'b000:  alu_result_e = src_a + src_b;
            3'b001:  alu_result_e = src_a - src_b;
            3'b010:  alu_result_e = src_a & src_b;
            3'b011:  alu_result_e = src_a | src_b;
            3'b101:  alu_result_e = ($signed(src_a) < $signed(src_b)) ? 32'h1 : 32'h0;
            default: alu_result_e = 32'h0;
        endcase
    end

    assign zero_e    = (alu_result_e == 32'h0);
    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= 5'd0;
            PCPlus4M    <= 32'h0;
            WriteDataM  <= 32'h0;
            ALU_ResultM <= 32'h0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= write_data_e;
            ALU_ResultM <= alu_result_e;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: expected EX/MEM contents are queued
// when a cycle is driven and popped after the capturing edge.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    logic [103:0] exp_q[$];
    logic [103:0] exp_v;
    logic [103:0] m_vec;
    logic [31:0]  last_alu;
    int n_vec  = 0;
    int n_miss = 0;

    assign m_vec = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
        .ForwardB_E(ForwardB_E), .ResultW(ResultW), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    function automatic logic [103:0] pack_m(input logic rw, input logic mw, input logic rs,
                                            input logic [4:0] rd, input logic [31:0] pc4,
                                            input logic [31:0] wd, input logic [31:0] alu);
        return {rw, mw, rs, rd, pc4, wd, alu};
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_idle();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0; BranchE = 0;
        ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
        PCPlus4E = 0; RD_E = 0; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
    endtask

    task automatic drive_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControlE = op; RD1_E = a; RD2_E = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd9;
        PCPlus4E = 32'h1234; drive_alu(3'd0, 32'h11, 32'h22);
        #2;
        n_vec++;
        if (m_vec !== 104'h0) begin
            n_miss++; $display("FAIL reset_initial: got %h want 0", m_vec);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m_vec !== 104'h0) begin
            n_miss++; $display("FAIL reset_held: got %h want 0", m_vec);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (m_vec !== 104'h0) begin
            n_miss++; $display("FAIL reset_release_pre_edge: got %h want 0", m_vec);
        end
        exp_q.push_back(pack_m(1, 1, 1, 5'd9, 32'h1234, 32'h22, 32'h33));
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (m_vec !== exp_v) begin
            n_miss++; $display("FAIL reset_first_capture: got %h want %h", m_vec, exp_v);
        end
        // mid-stream async reset between edges
        drive_alu(3'd1, 32'h50, 32'h8); RD_E = 5'd3;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (m_vec !== 104'h0) begin
            n_miss++; $display("FAIL reset_async_midstream: got %h want 0", m_vec);
        end
        @(posedge clk); #1;
        n_vec++;
        if (m_vec !== 104'h0) begin
            n_miss++; $display("FAIL reset_discard_inflight: got %h want 0", m_vec);
        end
        #2 reset = 1'b1;
        exp_q.push_back(pack_m(1, 1, 1, 5'd3, 32'h1234, 32'h8, 32'h48));
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (m_vec !== exp_v) begin
            n_miss++; $display("FAIL reset_recover_capture: got %h want %h", m_vec, exp_v);
        end
        last_alu = exp_v[31:0];
    endtask

    logic [2:0]  alu_ops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd7};
    logic [31:0] alu_exp [8] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0};

    task automatic test_alu();
        set_idle();
        for (int i = 0; i < 8; i++) begin
            drive_alu(alu_ops[i], 32'd7, 32'd5);
            exp_q.push_back(pack_m(0, 0, 0, 5'd0, 32'h0, 32'd5, alu_exp[i]));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (m_vec !== exp_v) begin
                n_miss++; $display("FAIL alu_op%0d: got %h want %h", alu_ops[i], m_vec, exp_v);
            end
        end
        // wrap, signed compare, and a case an unsigned compare would get wrong
        drive_alu(3'd0, 32'hFFFFFFFF, 32'h1); exp_q.push_back(pack_m(0, 0, 0, 0, 0, 32'h1, 32'h0));
        @(posedge clk); #1; exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL alu_add_wrap: got %h want %h", m_vec, exp_v); end
        drive_alu(3'd5, 32'hFFFFFFFF, 32'h1); exp_q.push_back(pack_m(0, 0, 0, 0, 0, 32'h1, 32'h1));
        @(posedge clk); #1; exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL alu_slt_neg: got %h want %h", m_vec, exp_v); end
        drive_alu(3'd5, 32'h1, 32'hFFFFFFFF); exp_q.push_back(pack_m(0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0));
        @(posedge clk); #1; exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL alu_slt_pos: got %h want %h", m_vec, exp_v); end
        drive_alu(3'd1, 32'h0, 32'h1); exp_q.push_back(pack_m(0, 0, 0, 0, 0, 32'h1, 32'hFFFFFFFF));
        @(posedge clk); #1; exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL alu_sub_wrap: got %h want %h", m_vec, exp_v); end
    endtask

    logic [1:0]  fw_a   [6] = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [1:0]  fw_b   [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    logic [2:0]  fw_op  [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    logic [31:0] fw_rd1 [6] = '{32'h10, 32'hDEAD, 32'h4, 32'h77, 32'h77, 32'h2};
    logic [31:0] fw_rd2 [6] = '{32'h0, 32'hBEEF, 32'h1, 32'h66, 32'h66, 32'h6};
    logic [31:0] fw_wd  [6] = '{32'h0, 32'h3, 32'h1, 32'h5, 32'hA, 32'h6};
    logic [31:0] fw_alu [6] = '{32'h10, 32'h13, 32'h5, 32'hA, 32'h0, 32'h8};

    task automatic test_forwarding();
        set_idle();
        ResultW = 32'h3;
        for (int i = 0; i < 6; i++) begin
            drive_alu(fw_op[i], fw_rd1[i], fw_rd2[i]);
            ForwardA_E = fw_a[i]; ForwardB_E = fw_b[i];
            if (i == 5) ResultW = 32'h99;
            exp_q.push_back(pack_m(0, 0, 0, 0, 0, fw_wd[i], fw_alu[i]));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (m_vec !== exp_v) begin
                n_miss++; $display("FAIL fwd_step%0d: got %h want %h", i, m_vec, exp_v);
            end
        end
    endtask

    task automatic test_imm_store();
        set_idle();
        ALUSrcE = 1; Imm_Ext_E = 32'd8; MemWriteE = 1; drive_alu(3'd0, 32'd100, 32'hAB);
        exp_q.push_back(pack_m(0, 1, 0, 0, 0, 32'hAB, 32'd108));
        @(posedge clk); #1; exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL imm_store: got %h want %h", m_vec, exp_v); end
        ForwardB_E = 2'd1; ResultW = 32'h55;
        exp_q.push_back(pack_m(0, 1, 0, 0, 0, 32'h55, 32'd108));
        @(posedge clk); #1; exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL imm_store_fwd: got %h want %h", m_vec, exp_v); end
    endtask

    logic        br_en  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] br_rd2 [4] = '{32'd9, 32'd9, 32'd8, 32'd9};
    logic        br_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    task automatic test_branch();
        set_idle();
        PCE = 32'h40; Imm_Ext_E = 32'hFFFFFFF8;
        for (int i = 0; i < 4; i++) begin
            BranchE = br_en[i]; drive_alu(3'd1, 32'd9, br_rd2[i]);
            #1;
            n_vec++;
            if ({PCSrcE, PCTargetE} !== {br_exp[i], 32'h38}) begin
                n_miss++;
                $display("FAIL branch_case%0d: got src=%b tgt=%h want src=%b tgt=38",
                         i, PCSrcE, PCTargetE, br_exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_control();
        set_idle();
        RegWriteE = 1; ResultSrcE = 1; RD_E = 5'd31; PCPlus4E = 32'h44;
        exp_q.push_back(pack_m(1, 0, 1, 5'd31, 32'h44, 0, 0));
        @(posedge clk); #1;
        RegWriteE = 0; ResultSrcE = 0; MemWriteE = 1; RD_E = 5'd0; PCPlus4E = 32'h48;
        exp_q.push_back(pack_m(0, 1, 0, 5'd0, 32'h48, 0, 0));
        exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL ctrl_on: got %h want %h", m_vec, exp_v); end
        @(posedge clk); #1;
        exp_v = exp_q.pop_front(); n_vec++;
        if (m_vec !== exp_v) begin n_miss++; $display("FAIL ctrl_off: got %h want %h", m_vec, exp_v); end
        last_alu = 32'h0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, wd;
        logic [2:0]  op;
        for (int i = 0; i < 40; i++) begin
            RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
            ResultSrcE = 1'($urandom_range(0, 1)); ALUSrcE = 1'($urandom_range(0, 1));
            BranchE = 0; ALUControlE = 3'($urandom_range(0, 7));
            RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; ResultW = $urandom;
            PCPlus4E = $urandom; RD_E = 5'($urandom_range(0, 31));
            ForwardA_E = 2'($urandom_range(0, 3)); ForwardB_E = 2'($urandom_range(0, 3));
            a  = (ForwardA_E == 2'd1) ? ResultW : (ForwardA_E == 2'd2) ? last_alu : RD1_E;
            wd = (ForwardB_E == 2'd1) ? ResultW : (ForwardB_E == 2'd2) ? last_alu : RD2_E;
            b  = ALUSrcE ? Imm_Ext_E : wd;
            op = ALUControlE;
            exp_q.push_back(pack_m(RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, wd,
                                   alu_model(op, a, b)));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (m_vec !== exp_v) begin
                n_miss++; $display("FAIL random%0d: got %h want %h", i, m_vec, exp_v);
            end
            last_alu = exp_v[31:0];
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forwarding();
        test_imm_store();
        test_branch();
        test_control();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
